// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared sizes, FSM states and requester ids for the RAM port arbiter
package mem_port_arbiter_pkg;
  localparam int MEM_BYTES_DEF = 800;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  typedef enum logic {REQ_IF, REQ_D} req_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU-side request/response and RAM-side signals of the arbiter
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  logic              mem_reset;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
    output if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_reset, mem_address, mem_write_en, mem_write_data
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
    input  if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_reset, mem_address, mem_write_en, mem_write_data
  );
endinterface

// File: rtl/mem_port_arbiter_addr_check.sv
// mem_port_arbiter_addr_check: flags misaligned or out-of-range word accesses
module mem_port_arbiter_addr_check #(
  parameter int MEM_BYTES = 800,
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              bad_o
);
  assign bad_o = (|addr_i[1:0]) || (addr_i > ADDR_W'(MEM_BYTES - 4));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between fetch and data with round-robin and registered responses
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  state_e state_q, state_d;
  req_e last_q, last_d;
  logic if_bad, d_bad, run, if_gnt, d_gnt;
  logic if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
  logic d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  mem_port_arbiter_addr_check #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) u_if_chk (
    .addr_i(bus.if_addr),
    .bad_o (if_bad)
  );
  mem_port_arbiter_addr_check #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) u_d_chk (
    .addr_i(bus.d_addr),
    .bad_o (d_bad)
  );
  assign run = state_q == ST_RUN;
  // on a tie the requester that did not win last time gets the slot
  always_comb begin
    state_d = ST_RUN;
    if_gnt = run && bus.if_req && (!bus.d_req || last_q == REQ_D);
    d_gnt = run && bus.d_req && !if_gnt;
    last_d = if_gnt ? REQ_IF : d_gnt ? REQ_D : last_q;
    if_rvalid_d = if_gnt;
    if_err_d = if_gnt && if_bad;
    if_rdata_d = (if_gnt && !if_bad) ? bus.mem_read_data : '0;
    d_rvalid_d = d_gnt;
    d_err_d = d_gnt && d_bad;
    d_rdata_d = (d_gnt && !d_bad && !bus.d_we) ? bus.mem_read_data : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      last_q <= REQ_D;
      if_rvalid_q <= 1'b0;
      if_err_q <= 1'b0;
      if_rdata_q <= '0;
      d_rvalid_q <= 1'b0;
      d_err_q <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      if_rvalid_q <= if_rvalid_d;
      if_err_q <= if_err_d;
      if_rdata_q <= if_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_err_q <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign bus.if_gnt = if_gnt;
  assign bus.d_gnt = d_gnt;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_err = if_err_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_err = d_err_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.mem_reset = !run;
  assign bus.mem_address = if_gnt ? bus.if_addr : d_gnt ? bus.d_addr : '0;
  assign bus.mem_write_en = d_gnt && bus.d_we && !d_bad;
  assign bus.mem_write_data = bus.d_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: RAM model, reference scoreboard and directed scenarios for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  localparam int MB = 800;
  localparam int NW = MB / 4;
  typedef struct {logic [31:0] d; logic e;} rsp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0, n_pass = 0;
  logic [31:0] ram [NW];
  logic [31:0] ref_mem [NW];
  rsp_t if_q[$], d_q[$];
  logic run_m = 1'b0, ig_m = 1'b0, dg_m = 1'b0, wr_m = 1'b0;
  req_e last_m = REQ_D;
  logic [31:0] wa_m = '0, wd_m = '0;
  mem_port_arbiter_if b ();
  mem_port_arbiter #(.MEM_BYTES(MB)) dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  function automatic logic [31:0] img(input int i);
    return i == 0 ? 32'hE3A00005 : 32'h1000_0000 + 32'(i) * 32'h0101;
  endfunction
  function automatic logic bad_m(input logic [31:0] a);
    return a[1:0] != 2'b00 || a > 32'(MB - 4);
  endfunction
  always @(posedge clk) begin
    if (b.mem_reset) for (int i = 0; i < NW; i++) ram[i] <= img(i);
    else if (b.mem_write_en && b.mem_address < 32'(MB)) ram[b.mem_address[31:2]] <= b.mem_write_data;
  end
  always_comb b.mem_read_data = b.mem_address < 32'(MB) ? ram[b.mem_address[31:2]] : 32'h0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      run_m <= 1'b0;
      last_m <= REQ_D;
      for (int i = 0; i < NW; i++) ref_mem[i] <= img(i);
    end else begin
      if (!run_m) for (int i = 0; i < NW; i++) ref_mem[i] <= img(i);
      else if (wr_m) ref_mem[wa_m[31:2]] <= wd_m;
      run_m <= 1'b1;
      if (ig_m) last_m <= REQ_IF;
      else if (dg_m) last_m <= REQ_D;
    end
  end
  always @(negedge clk) begin
    logic eig, edg, ev, ewe;
    logic [31:0] ea;
    rsp_t r;
    if (reset) begin
      if_q.delete();
      d_q.delete();
      ig_m = 1'b0;
      dg_m = 1'b0;
      wr_m = 1'b0;
      n_chk++;
      if ({b.if_gnt, b.d_gnt, b.if_rvalid, b.d_rvalid, b.if_err, b.d_err, b.mem_write_en, b.mem_reset} !== 8'b00000001
          || b.if_rdata !== 32'h0 || b.d_rdata !== 32'h0 || b.mem_address !== 32'h0)
        $display("FAIL reset_outputs: flags=%b if_rdata=%h d_rdata=%h addr=%h, required flags=00000001 and zeros",
                 {b.if_gnt, b.d_gnt, b.if_rvalid, b.d_rvalid, b.if_err, b.d_err, b.mem_write_en, b.mem_reset},
                 b.if_rdata, b.d_rdata, b.mem_address);
      else n_pass++;
    end else begin
      eig = run_m && b.if_req && (!b.d_req || last_m == REQ_D);
      edg = run_m && b.d_req && !eig;
      n_chk++;
      if ({b.if_gnt, b.d_gnt, b.mem_reset} !== {eig, edg, !run_m})
        $display("FAIL sb_grant: if_gnt,d_gnt,mem_reset=%b required %b", {b.if_gnt, b.d_gnt, b.mem_reset}, {eig, edg, !run_m});
      else n_pass++;
      ev = if_q.size() != 0;
      r = ev ? if_q.pop_front() : '{d: 32'h0, e: 1'b0};
      n_chk++;
      if ({b.if_rvalid, b.if_err, b.if_rdata} !== {ev, r.e, r.d})
        $display("FAIL sb_if_rsp: valid,err,rdata=%b,%b,%h required %b,%b,%h", b.if_rvalid, b.if_err, b.if_rdata, ev, r.e, r.d);
      else n_pass++;
      ev = d_q.size() != 0;
      r = ev ? d_q.pop_front() : '{d: 32'h0, e: 1'b0};
      n_chk++;
      if ({b.d_rvalid, b.d_err, b.d_rdata} !== {ev, r.e, r.d})
        $display("FAIL sb_d_rsp: valid,err,rdata=%b,%b,%h required %b,%b,%h", b.d_rvalid, b.d_err, b.d_rdata, ev, r.e, r.d);
      else n_pass++;
      ea = eig ? b.if_addr : edg ? b.d_addr : 32'h0;
      ewe = edg && b.d_we && !bad_m(b.d_addr);
      n_chk++;
      if (b.mem_address !== ea || b.mem_write_en !== ewe || (ewe && b.mem_write_data !== b.d_wdata))
        $display("FAIL sb_mem_bus: addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                 b.mem_address, b.mem_write_en, b.mem_write_data, ea, ewe, b.d_wdata);
      else n_pass++;
      if (eig) if_q.push_back(bad_m(b.if_addr) ? '{d: 32'h0, e: 1'b1} : '{d: ref_mem[b.if_addr[31:2]], e: 1'b0});
      if (edg) d_q.push_back(bad_m(b.d_addr) ? '{d: 32'h0, e: 1'b1}
                             : '{d: b.d_we ? 32'h0 : ref_mem[b.d_addr[31:2]], e: 1'b0});
      ig_m = eig;
      dg_m = edg;
      wr_m = ewe;
      wa_m = b.d_addr;
      wd_m = b.d_wdata;
    end
  end
  task automatic wait_gnt(input bit is_d, input string nm);
    bit g = 1'b0;
    for (int k = 0; k < 20 && !g; k++) begin
      @(negedge clk);
      g = is_d ? b.d_gnt : b.if_gnt;
    end
    n_chk++;
    if (!g) $display("FAIL %s_gnt_timeout: gnt=0 after 20 cycles, required 1", nm);
    else n_pass++;
  endtask
  task automatic test_reset;
    b.if_req = 1'b1;
    b.if_addr = 32'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (b.mem_reset !== 1'b1 || b.if_gnt !== 1'b0) $display("FAIL init_hold: mem_reset=%b if_gnt=%b required 1,0", b.mem_reset, b.if_gnt);
    else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_chk++;
    if (b.mem_reset !== 1'b1 || b.if_gnt !== 1'b0) $display("FAIL init_after_release: mem_reset=%b if_gnt=%b required 1,0", b.mem_reset, b.if_gnt);
    else n_pass++;
    wait_gnt(1'b0, "if_first");
    n_chk++;
    if (b.mem_reset !== 1'b0) $display("FAIL run_mem_reset: mem_reset=%b required 0", b.mem_reset);
    else n_pass++;
    @(posedge clk);
    #1 b.if_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (b.if_rvalid !== 1'b1 || b.if_rdata !== 32'hE3A00005) $display("FAIL if_first_rsp: rvalid=%b rdata=%h required 1,e3a00005", b.if_rvalid, b.if_rdata);
    else n_pass++;
  endtask
  task automatic test_write_read;
    @(posedge clk);
    #1 {b.d_req, b.d_we, b.d_addr, b.d_wdata} = {1'b1, 1'b1, 32'h20, 32'hDEADBEEF};
    wait_gnt(1'b1, "d_write");
    @(posedge clk);
    #1 b.d_we = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({b.d_rvalid, b.d_err, b.d_gnt} !== 3'b101 || b.d_rdata !== 32'h0)
      $display("FAIL write_ack: rvalid,err,gnt=%b rdata=%h required 101, 0", {b.d_rvalid, b.d_err, b.d_gnt}, b.d_rdata);
    else n_pass++;
    @(posedge clk);
    #1 b.d_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (b.d_rvalid !== 1'b1 || b.d_rdata !== 32'hDEADBEEF) $display("FAIL read_after_write: rvalid=%b rdata=%h required 1,deadbeef", b.d_rvalid, b.d_rdata);
    else n_pass++;
  endtask
  task automatic test_contention;
    @(posedge clk);
    #1 {b.if_req, b.if_addr, b.d_req, b.d_we, b.d_addr} = {1'b1, 32'h4, 1'b1, 1'b0, 32'h8};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if ({b.if_gnt, b.d_gnt} !== (i % 2 == 0 ? 2'b10 : 2'b01)) $display("FAIL rr_grant_%0d: if,d gnt=%b required %b", i, {b.if_gnt, b.d_gnt}, i % 2 == 0 ? 2'b10 : 2'b01);
      else n_pass++;
      if (i > 0) begin
        n_chk++;
        if ({b.if_rvalid, b.d_rvalid} !== (i % 2 == 1 ? 2'b10 : 2'b01) || (i % 2 == 1 ? b.if_rdata !== img(1) : b.d_rdata !== img(2)))
          $display("FAIL rr_rsp_%0d: if,d rvalid=%b if_rdata=%h d_rdata=%h", i, {b.if_rvalid, b.d_rvalid}, b.if_rdata, b.d_rdata);
        else n_pass++;
      end
    end
    @(posedge clk);
    #1 {b.if_req, b.d_req} = 2'b00;
    @(negedge clk);
    n_chk++;
    if ({b.if_rvalid, b.d_rvalid} !== 2'b01 || b.d_rdata !== img(2)) $display("FAIL rr_last_rsp: if,d rvalid=%b d_rdata=%h required 01,%h", {b.if_rvalid, b.d_rvalid}, b.d_rdata, img(2));
    else n_pass++;
  endtask
  task automatic test_bad_addr;
    @(posedge clk);
    #1 {b.d_req, b.d_we, b.d_addr, b.d_wdata} = {1'b1, 1'b1, 32'h21, 32'hBAD0BAD0};
    wait_gnt(1'b1, "d_bad_write");
    n_chk++;
    if (b.mem_write_en !== 1'b0) $display("FAIL bad_write_en: mem_write_en=%b required 0", b.mem_write_en);
    else n_pass++;
    @(posedge clk);
    #1 {b.d_we, b.d_addr} = {1'b0, 32'h22};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++;
      if ({b.d_rvalid, b.d_err} !== 2'b11 || b.d_rdata !== 32'h0) $display("FAIL bad_rsp_%0d: rvalid,err=%b rdata=%h required 11,0", i, {b.d_rvalid, b.d_err}, b.d_rdata);
      else n_pass++;
      @(posedge clk);
      #1 b.d_addr = 32'(MB - 2);
    end
    b.d_req = 1'b0;
    {b.if_req, b.if_addr} = {1'b1, 32'(MB - 4)};
    @(negedge clk);
    n_chk++;
    if ({b.d_rvalid, b.d_err, b.if_gnt} !== 3'b111 || b.d_rdata !== 32'h0) $display("FAIL bad_top_rsp: rvalid,err,if_gnt=%b rdata=%h required 111,0", {b.d_rvalid, b.d_err, b.if_gnt}, b.d_rdata);
    else n_pass++;
    @(posedge clk);
    #1 {b.if_req, b.d_req, b.d_addr} = {1'b0, 1'b1, 32'h20};
    @(negedge clk);
    n_chk++;
    if ({b.if_rvalid, b.if_err} !== 2'b10 || b.if_rdata !== img(NW - 1)) $display("FAIL last_word: rvalid,err=%b rdata=%h required 10,%h", {b.if_rvalid, b.if_err}, b.if_rdata, img(NW - 1));
    else n_pass++;
    @(posedge clk);
    #1 b.d_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (b.d_rdata !== 32'hDEADBEEF) $display("FAIL bad_write_kept_out: rdata=%h required deadbeef", b.d_rdata);
    else n_pass++;
  endtask
  task automatic test_drop;
    @(posedge clk);
    #1 {b.if_req, b.if_addr, b.d_req, b.d_we, b.d_addr} = {1'b1, 32'h0, 1'b1, 1'b0, 32'h10};
    @(negedge clk);
    n_chk++;
    if ({b.if_gnt, b.d_gnt} !== 2'b10) $display("FAIL drop_first: if,d gnt=%b required 10", {b.if_gnt, b.d_gnt});
    else n_pass++;
    for (int i = 1; i < 6; i++) begin
      @(posedge clk);
      #1 {b.d_req, b.if_addr} = {1'b0, 32'(4 * i)};
      @(negedge clk);
      n_chk++;
      if ({b.if_gnt, b.if_rvalid, b.d_rvalid} !== 3'b110 || b.if_rdata !== img(i - 1))
        $display("FAIL if_stream_%0d: gnt,if_rv,d_rv=%b rdata=%h required 110,%h", i, {b.if_gnt, b.if_rvalid, b.d_rvalid}, b.if_rdata, img(i - 1));
      else n_pass++;
    end
    @(posedge clk);
    #1 b.if_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({b.if_rvalid, b.d_rvalid} !== 2'b10 || b.if_rdata !== img(5)) $display("FAIL if_stream_end: if,d rvalid=%b rdata=%h required 10,%h", {b.if_rvalid, b.d_rvalid}, b.if_rdata, img(5));
    else n_pass++;
  endtask
  task automatic test_reset_mid;
    @(posedge clk);
    #1 {b.if_req, b.if_addr, b.d_req, b.d_we, b.d_addr, b.d_wdata} = {1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D};
    @(negedge clk);
    n_chk++;
    if ({b.if_gnt, b.d_gnt, b.mem_write_en} !== 3'b011) $display("FAIL mid_pre: if,d gnt,we=%b required 011", {b.if_gnt, b.d_gnt, b.mem_write_en});
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({b.d_gnt, b.mem_write_en, b.mem_reset} !== 3'b001) $display("FAIL mid_async: gnt,we,mem_reset=%b required 001", {b.d_gnt, b.mem_write_en, b.mem_reset});
    else n_pass++;
    @(posedge clk);
    #1 {b.if_req, b.d_req} = 2'b00;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({b.if_rvalid, b.d_rvalid, b.mem_reset} !== 3'b001) $display("FAIL mid_no_rsp: if_rv,d_rv,mem_reset=%b required 001", {b.if_rvalid, b.d_rvalid, b.mem_reset});
    else n_pass++;
    @(posedge clk);
    #1 {b.d_req, b.d_we, b.d_addr} = {1'b1, 1'b0, 32'h40};
    wait_gnt(1'b1, "d_after_reset");
    @(posedge clk);
    #1 b.d_addr = 32'h20;
    @(negedge clk);
    n_chk++;
    if (b.d_rdata !== img(16)) $display("FAIL mid_write_dropped: rdata=%h required %h", b.d_rdata, img(16));
    else n_pass++;
    @(posedge clk);
    #1 b.d_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (b.d_rdata !== img(8)) $display("FAIL mid_ram_reinit: rdata=%h required %h", b.d_rdata, img(8));
    else n_pass++;
  endtask
  initial begin
    {b.if_req, b.if_addr, b.d_req, b.d_we, b.d_addr, b.d_wdata} = '0;
    test_reset();
    test_write_read();
    test_contention();
    test_bad_addr();
    test_drop();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1);
  end
endmodule
